// File: rtl/sram_arb_rr.sv
// Round-robin grant for the shared SRAM port: wrap-around priority search
// starting at rr_q, pointer advances past each winner.
module sram_arb_rr #(
    parameter int unsigned  NumReq   = 4,
    localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumReq-1:0]   req,
    output logic [NumReq-1:0]   gnt,
    output logic [IdxWidth-1:0] idx
);

    if (NumReq == 1) begin : g_single
        assign gnt = req;
        assign idx = '0;
    end else begin : g_rr
        logic [IdxWidth-1:0] rr_q;
        logic                found;
        int unsigned         cand;
        logic [IdxWidth-1:0] cand_idx;

        always_comb begin
            gnt      = '0;
            idx      = '0;
            found    = 1'b0;
            cand     = 0;
            cand_idx = '0;
            for (int unsigned k = 0; k < NumReq; k++) begin
                cand = 32'(rr_q) + k;
                if (cand >= NumReq) begin
                    cand = cand - NumReq;
                end
                cand_idx = cand[IdxWidth-1:0];
                if (!found && req[cand_idx]) begin
                    found         = 1'b1;
                    gnt[cand_idx] = 1'b1;
                    idx           = cand_idx;
                end
            end
        end

        // any request implies a grant, so |req is the grant-taken flag
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rr_q <= '0;
            end else if (|req) begin
                rr_q <= (idx == IdxWidth'(NumReq - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM macro port among NumReq req/gnt requesters; read responses
// are tagged with the requester id and retired Latency cycles after grant.
module sram_port_arbiter #(
    parameter int unsigned  NumReq    = 4,
    parameter int unsigned  NumWords  = 1024,
    parameter int unsigned  DataWidth = 32,
    parameter int unsigned  ByteWidth = 8,
    parameter int unsigned  Latency   = 1,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
    localparam int unsigned IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumReq-1:0]                 req_i,
    output logic [NumReq-1:0]                 gnt_o,
    input  logic [NumReq-1:0]                 we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]  addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]  wdata_i,
    input  logic [NumReq-1:0][BeWidth-1:0]    be_i,
    output logic [NumReq-1:0]                 rvalid_o,
    output logic [DataWidth-1:0]              rdata_o,
    output logic                              sram_req_o,
    output logic                              sram_we_o,
    output logic [AddrWidth-1:0]              sram_addr_o,
    output logic [DataWidth-1:0]              sram_wdata_o,
    output logic [BeWidth-1:0]                sram_be_o,
    input  logic [DataWidth-1:0]              sram_rdata_i
);

    logic [IdxWidth-1:0] idx;

    sram_arb_rr #(
        .NumReq (NumReq)
    ) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    (req_i),
        .gnt    (gnt_o),
        .idx    (idx)
    );

    // idle payload is forced to zero so the macro never sees a stray address
    always_comb begin
        sram_req_o   = |gnt_o;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (|gnt_o) begin
            sram_we_o    = we_i[idx];
            sram_addr_o  = addr_i[idx];
            sram_wdata_o = wdata_i[idx];
            sram_be_o    = be_i[idx];
        end
    end

    assign rdata_o = sram_rdata_i;

    if (Latency == 0) begin : g_lat0
        assign rvalid_o = gnt_o & ~we_i;
    end else begin : g_pipe
        logic [Latency-1:0]               valid_q;
        logic [Latency-1:0][IdxWidth-1:0] id_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= '0;
                id_q    <= '0;
            end else begin
                valid_q[0] <= (|gnt_o) & ~sram_we_o;
                id_q[0]    <= idx;
                for (int unsigned k = 1; k < Latency; k++) begin
                    valid_q[k] <= valid_q[k-1];
                    id_q[k]    <= id_q[k-1];
                end
            end
        end

        always_comb begin
            rvalid_o = '0;
            if (valid_q[Latency-1]) begin
                rvalid_o[id_q[Latency-1]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Drives three arbiter instances (Latency 0, 1, 3) with one shared stimulus
// and checks them every cycle against a transaction-level reference model.
module tb_sram_port_arbiter;

    localparam int N    = 4;
    localparam int NDUT = 3;

    logic clk;
    logic rst_n;
    logic mem_load;

    logic [N-1:0]        req;
    logic [N-1:0]        we;
    logic [N-1:0][9:0]   addr;
    logic [N-1:0][31:0]  wdata;
    logic [N-1:0][3:0]   be;

    logic [N-1:0] gnt_d    [NDUT];
    logic [N-1:0] rvalid_d [NDUT];
    logic [31:0]  rdata_d  [NDUT];
    logic         sreq_d   [NDUT];
    logic         swe_d    [NDUT];
    logic [9:0]   saddr_d  [NDUT];
    logic [31:0]  swdata_d [NDUT];
    logic [3:0]   sbe_d    [NDUT];
    logic [31:0]  srdata_d [NDUT];

    int checks   = 0;
    int failures = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    function automatic logic [31:0] init_word(input int k);
        return 32'hA5A5_0000 | 32'(k);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar d = 0; d < NDUT; d++) begin : g_dut
        localparam int unsigned L = (d == 0) ? 0 : ((d == 1) ? 1 : 3);
        logic [31:0] mem [32];
        logic [31:0] rp  [3];

        sram_port_arbiter #(
            .NumReq    (4),
            .NumWords  (1024),
            .DataWidth (32),
            .ByteWidth (8),
            .Latency   (L)
        ) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .req_i        (req),
            .gnt_o        (gnt_d[d]),
            .we_i         (we),
            .addr_i       (addr),
            .wdata_i      (wdata),
            .be_i         (be),
            .rvalid_o     (rvalid_d[d]),
            .rdata_o      (rdata_d[d]),
            .sram_req_o   (sreq_d[d]),
            .sram_we_o    (swe_d[d]),
            .sram_addr_o  (saddr_d[d]),
            .sram_wdata_o (swdata_d[d]),
            .sram_be_o    (sbe_d[d]),
            .sram_rdata_i (srdata_d[d])
        );

        // macro model: write with byte enables, read data delayed L cycles
        always @(posedge clk) begin
            if (mem_load) begin
                for (int k = 0; k < 32; k++) mem[k] <= init_word(k);
            end else if (sreq_d[d] && swe_d[d]) begin
                for (int b = 0; b < 4; b++)
                    if (sbe_d[d][b]) mem[saddr_d[d][4:0]][8*b +: 8] <= swdata_d[d][8*b +: 8];
            end
            rp[0] <= mem[saddr_d[d][4:0]];
            rp[1] <= rp[0];
            rp[2] <= rp[1];
        end

        if (L == 0) begin : g_comb
            assign srdata_d[d] = mem[saddr_d[d][4:0]];
        end else begin : g_reg
            assign srdata_d[d] = rp[L-1];
        end
    end

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s lat=%0d t=%0t got=%h want=%h", name, lat_of(d), $time, act, exp);
        end
    endtask

    // reference model state
    int          cyc      = 0;
    int          last_rst = -1;
    int          m_rr     = 0;
    int          m_g      = -1;
    logic        prev_ok  = 1'b0;
    int          prev_g   = -1;
    logic        prev_we;
    logic [4:0]  prev_addr;
    logic [31:0] prev_wdata;
    logic [3:0]  prev_be;
    logic [31:0] refmem   [32];
    int          hist_id  [4096];
    logic [31:0] hist_dat [4096];

    initial for (int k = 0; k < 32; k++) refmem[k] = init_word(k);

    always @(negedge clk) begin
        int          src;
        int          j;
        logic [N-1:0] ex_gnt;
        logic [N-1:0] ex_rv;
        logic [31:0]  ex_rd;
        logic [46:0]  ex_pl;

        // retire what the previous cycle transferred
        if (prev_ok && prev_g >= 0) begin
            if (prev_we)
                for (int b = 0; b < 4; b++)
                    if (prev_be[b]) refmem[prev_addr][8*b +: 8] = prev_wdata[8*b +: 8];
            m_rr = (prev_g + 1) % N;
        end
        if (!rst_n) begin
            m_rr     = 0;
            last_rst = cyc;
        end

        m_g = -1;
        for (int k = 0; k < N; k++) begin
            j = (m_rr + k) % N;
            if (m_g < 0 && req[j]) m_g = j;
        end
        ex_gnt = '0;
        ex_pl  = '0;
        if (m_g >= 0) begin
            ex_gnt[m_g] = 1'b1;
            ex_pl = {we[m_g], addr[m_g], wdata[m_g], be[m_g]};
        end
        hist_id[cyc]  = (rst_n && m_g >= 0 && !we[m_g]) ? m_g : -1;
        hist_dat[cyc] = (m_g >= 0) ? refmem[addr[m_g][4:0]] : 32'h0;

        for (int d = 0; d < NDUT; d++) begin
            ex_rv = '0;
            ex_rd = '0;
            if (lat_of(d) == 0) begin
                if (m_g >= 0 && !we[m_g]) begin
                    ex_rv[m_g] = 1'b1;
                    ex_rd      = hist_dat[cyc];
                end
            end else begin
                src = cyc - lat_of(d);
                if (src >= 0 && src > last_rst && hist_id[src] >= 0) begin
                    ex_rv[hist_id[src]] = 1'b1;
                    ex_rd               = hist_dat[src];
                end
            end
            chk("gnt", d, 64'(gnt_d[d]), 64'(ex_gnt));
            chk("sram_req", d, 64'(sreq_d[d]), 64'(m_g >= 0));
            chk("payload", d, 64'({swe_d[d], saddr_d[d], swdata_d[d], sbe_d[d]}), 64'(ex_pl));
            chk("rvalid", d, 64'(rvalid_d[d]), 64'(ex_rv));
            if (ex_rv != '0) chk("rdata", d, 64'(rdata_d[d]), 64'(ex_rd));
        end

        prev_ok = rst_n;
        prev_g  = m_g;
        if (m_g >= 0) begin
            prev_we    = we[m_g];
            prev_addr  = addr[m_g][4:0];
            prev_wdata = wdata[m_g];
            prev_be    = be[m_g];
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic do_txn(input int i, input logic w, input logic [9:0] a,
                          input logic [31:0] wd, input logic [3:0] b);
        logic done;
        done     = 1'b0;
        we[i]    = w;
        addr[i]  = a;
        wdata[i] = wd;
        be[i]    = b;
        req[i]   = 1'b1;
        for (int n = 0; n < 16 && !done; n++) begin
            mid();
            if (m_g == i) done = 1'b1;
            tick();
        end
        req[i] = 1'b0;
        chk("txn_granted", 1, 64'(done), 64'(1));
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        rr_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n    = 1'b0;
        mem_load = 1'b1;
        req      = '1;
        we       = '0;
        wdata    = '0;
        be       = '0;
        for (int i = 0; i < N; i++) addr[i] = 10'(i);

        mid();
        chk("rst_rvalid", 1, 64'(rvalid_d[1]), 64'(0));
        chk("rst_rvalid", 2, 64'(rvalid_d[2]), 64'(0));
        chk("rst_gnt", 1, 64'(gnt_d[1]), 64'(4'b0001));
        tick();
        mem_load = 1'b0;
        mid();
        tick();
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            mid();
            chk("rr_seq", 1, 64'(gnt_d[1]), 64'(rr_exp[k]));
            chk("rr_sram_req", 1, 64'(sreq_d[1]), 64'(1));
            tick();
        end
        req = '0;
        repeat (4) tick();

        do_txn(2, 1'b1, 10'h010, 32'hDEAD_BEEF, 4'hF);
        do_txn(1, 1'b0, 10'h010, 32'h0, 4'h0);
        mid();
        chk("wr_rd_rvalid", 1, 64'(rvalid_d[1]), 64'(4'b0010));
        chk("wr_rd_rdata", 1, 64'(rdata_d[1]), 64'(32'hDEAD_BEEF));
        tick();

        do_txn(0, 1'b1, 10'h012, 32'hFFFF_FFFF, 4'hF);
        do_txn(3, 1'b1, 10'h012, 32'h1122_3344, 4'b0101);
        do_txn(3, 1'b0, 10'h012, 32'h0, 4'h0);
        mid();
        chk("be_rvalid", 1, 64'(rvalid_d[1]), 64'(4'b1000));
        chk("be_rdata", 1, 64'(rdata_d[1]), 64'(32'hFF22_FF44));
        tick();

        do_txn(0, 1'b0, 10'h010, 32'h0, 4'h0);
        tick();
        tick();
        mid();
        chk("lat3_rvalid", 2, 64'(rvalid_d[2]), 64'(4'b0001));
        chk("lat3_rdata", 2, 64'(rdata_d[2]), 64'(32'hDEAD_BEEF));
        tick();

        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && m_g == i) req[i] = 1'b0;
                if (!req[i] && $urandom_range(3) != 0) begin
                    req[i]   = 1'b1;
                    we[i]    = 1'($urandom_range(1));
                    addr[i]  = 10'($urandom_range(31));
                    wdata[i] = $urandom;
                    be[i]    = 4'($urandom_range(15));
                end
            end
            tick();
        end
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < N; i++)
                if (req[i] && m_g == i) req[i] = 1'b0;
            tick();
        end
        chk("drain", 1, 64'(req), 64'(0));
        req = '0;
        repeat (5) tick();

        // read in flight on the Latency=3 instance, then reset one cycle later
        we[2]   = 1'b0;
        addr[2] = 10'h010;
        req[2]  = 1'b1;
        mid();
        chk("mf_gnt", 2, 64'(gnt_d[2]), 64'(4'b0100));
        tick();
        req   = '0;
        rst_n = 1'b0;
        mid();
        chk("mf_rvalid", 2, 64'(rvalid_d[2]), 64'(0));
        tick();
        rst_n    = 1'b1;
        req      = 4'b1001;
        we       = '1;
        addr[0]  = 10'h014;
        addr[3]  = 10'h015;
        wdata[0] = 32'h0BAD_F00D;
        wdata[3] = 32'h1234_5678;
        be[0]    = 4'hF;
        be[3]    = 4'hF;
        mid();
        chk("mf_restart", 2, 64'(gnt_d[2]), 64'(4'b0001));
        for (int k = 0; k < 4; k++) begin
            tick();
            mid();
            chk("mf_no_rvalid", 2, 64'(rvalid_d[2]), 64'(0));
        end
        tick();
        req = '0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
